// File: rtl/lcd_stream_src.sv
// lcd_stream_src: word source and burst sequencer for the LCD write-strobe
// controller. It runs either a ROM-held init script (cmd/data/delay/end
// entries) or a solid-colour fill, and presents one word plus RS at a time.
// It advances on the controller's addr_en pulse.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no run in progress, waiting for a start request
// INI_NXT | evaluate the script entry at the pointer
// INI_RUN | script write burst active, one ROM entry per word
// INI_DLY | timing a script delay entry (prescaler + ms down-counters)
// COL_RUN | colour fill burst: 0x002C command, then PIXELS colour words
module lcd_stream_src #(
    parameter int ROM_AW     = 8,
    parameter int CLK_PER_MS = 50000,
    parameter int PIXELS     = 76800
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_ini_i,
    input  logic              start_color_i,
    input  logic [15:0]       color_i,
    input  logic              addr_en_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [18:0]       rom_data_i,
    output logic              data_trans_o,
    output logic              ini_en_o,
    output logic              color_en_o,
    output logic              data_stop_o,
    output logic              lcd_rs_o,
    output logic [15:0]       lcd_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INI_RUN = 3'd1,
        INI_DLY = 3'd2,
        INI_NXT = 3'd3,
        COL_RUN = 3'd4
    } state_t;

    localparam int               PW        = $clog2(CLK_PER_MS + 1);
    localparam logic [PW-1:0]    PRE_LOAD  = PW'(CLK_PER_MS - 1);
    localparam logic [ROM_AW-1:0] PTR_LAST = '1;
    // Last entry a burst may use; the entry at PTR_LAST is always an end.
    localparam logic [ROM_AW-1:0] PTR_PEN  = PTR_LAST - 1'b1;
    localparam logic [16:0]      PIX_LAST  = 17'(PIXELS);
    localparam logic [ROM_AW-1:0] PTR_ONE  = ROM_AW'(1);

    localparam logic [1:0] T_DELAY = 2'b10;
    localparam logic [1:0] T_END   = 2'b11;

    state_t            state;
    logic [ROM_AW-1:0] ptr;
    logic [PW-1:0]     pre_cnt;
    logic [15:0]       ms_cnt;
    logic [16:0]       pix_cnt;
    logic [15:0]       color_q;

    logic        ent_flag;
    logic [1:0]  ent_type;
    logic [15:0] ent_pay;
    logic        ent_last;

    assign ent_flag   = rom_data_i[18];
    assign ent_type   = rom_data_i[17:16];
    assign ent_pay    = rom_data_i[15:0];
    assign ent_last   = ent_flag || (ptr == PTR_PEN);
    assign rom_addr_o = ptr;
    assign busy_o     = (state != IDLE);

    // Sequencer: state, pointer, timers, colour latch and registered burst controls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            ptr          <= '0;
            pre_cnt      <= '0;
            ms_cnt       <= '0;
            pix_cnt      <= '0;
            color_q      <= '0;
            data_trans_o <= 1'b0;
            ini_en_o     <= 1'b0;
            color_en_o   <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ini_i) begin
                        ptr   <= '0;
                        state <= INI_NXT;
                    end else if (start_color_i) begin
                        color_q      <= color_i;
                        pix_cnt      <= '0;
                        data_trans_o <= 1'b1;
                        color_en_o   <= 1'b1;
                        state        <= COL_RUN;
                    end
                end
                INI_NXT: begin
                    if ((ptr == PTR_LAST) || (ent_type == T_END)) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end else if (ent_type == T_DELAY) begin
                        // A zero delay is skipped here instead of costing an INI_DLY cycle.
                        if (ent_pay == 16'd0) begin
                            ptr <= ptr + PTR_ONE;
                        end else begin
                            ms_cnt  <= ent_pay - 16'd1;
                            pre_cnt <= PRE_LOAD;
                            state   <= INI_DLY;
                        end
                    end else begin
                        data_trans_o <= 1'b1;
                        ini_en_o     <= 1'b1;
                        state        <= INI_RUN;
                    end
                end
                INI_DLY: begin
                    if (pre_cnt == '0) begin
                        if (ms_cnt == 16'd0) begin
                            ptr   <= ptr + PTR_ONE;
                            state <= INI_NXT;
                        end else begin
                            ms_cnt  <= ms_cnt - 16'd1;
                            pre_cnt <= PRE_LOAD;
                        end
                    end else begin
                        pre_cnt <= pre_cnt - 1'b1;
                    end
                end
                INI_RUN: begin
                    if (addr_en_i) begin
                        ptr <= ptr + PTR_ONE;
                        if (ent_last) begin
                            data_trans_o <= 1'b0;
                            ini_en_o     <= 1'b0;
                            state        <= INI_NXT;
                        end
                    end
                end
                COL_RUN: begin
                    if (addr_en_i) begin
                        pix_cnt <= pix_cnt + 17'd1;
                        if (pix_cnt == PIX_LAST) begin
                            data_trans_o <= 1'b0;
                            color_en_o   <= 1'b0;
                            done_o       <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word presented to the bus; only moves when pointer/counter step on addr_en.
    always_comb begin
        lcd_data_o  = 16'h0000;
        lcd_rs_o    = 1'b0;
        data_stop_o = 1'b0;
        case (state)
            INI_RUN: begin
                lcd_data_o  = ent_pay;
                lcd_rs_o    = ent_type[0];
                data_stop_o = ent_last;
            end
            COL_RUN: begin
                if (pix_cnt == 17'd0) begin
                    lcd_data_o = 16'h002C;
                    lcd_rs_o   = 1'b0;
                end else begin
                    lcd_data_o = color_q;
                    lcd_rs_o   = 1'b1;
                end
                data_stop_o = (pix_cnt == PIX_LAST);
            end
            default: begin
                lcd_data_o  = 16'h0000;
                lcd_rs_o    = 1'b0;
                data_stop_o = 1'b0;
            end
        endcase
    end

endmodule
